// File: rtl/nbyn_switch_buffered.sv
// Buffered 3x3 torus tile switch: per-input FIFOs, dimension-ordered routing,
// per-output round-robin arbitration and registered valid/ready outputs.
module nbyn_switch_buffered #(
    parameter int unsigned X_COORD    = 0,
    parameter int unsigned Y_COORD    = 0,
    parameter int unsigned X_W        = 4,
    parameter int unsigned Y_W        = 4,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid_l,
    input  logic [X_W+Y_W+DATA_W-1:0]    i_data_l,
    output logic                         o_ready_l,
    input  logic                         i_valid_b,
    input  logic [X_W+Y_W+DATA_W-1:0]    i_data_b,
    output logic                         o_ready_b,
    input  logic                         i_valid_pe,
    input  logic [X_W+Y_W+DATA_W-1:0]    i_data_pe,
    output logic                         o_ready_pe,
    output logic                         o_valid_r,
    output logic [X_W+Y_W+DATA_W-1:0]    o_data_r,
    input  logic                         i_ready_r,
    output logic                         o_valid_t,
    output logic [X_W+Y_W+DATA_W-1:0]    o_data_t,
    input  logic                         i_ready_t,
    output logic                         o_valid_ej,
    output logic [X_W+Y_W+DATA_W-1:0]    o_data_ej,
    input  logic                         i_ready_ej
);

    localparam int unsigned PKT_W = X_W + Y_W + DATA_W;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NPORT = 3;
    // Source indices L=0, B=1, PE=2; output indices R=0, T=1, EJ=2.
    localparam logic [1:0] OUT_R  = 2'd0;
    localparam logic [1:0] OUT_T  = 2'd1;
    localparam logic [1:0] OUT_EJ = 2'd2;

    logic [PKT_W-1:0] mem_q      [NPORT][FIFO_DEPTH];
    logic [PKT_W-1:0] mem_d      [NPORT][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q   [NPORT];
    logic [PTR_W-1:0] wr_ptr_d   [NPORT];
    logic [PTR_W-1:0] rd_ptr_q   [NPORT];
    logic [PTR_W-1:0] rd_ptr_d   [NPORT];
    logic [CNT_W-1:0] count_q    [NPORT];
    logic [CNT_W-1:0] count_d    [NPORT];
    logic [1:0]       rr_ptr_q   [NPORT];
    logic [1:0]       rr_ptr_d   [NPORT];
    logic             out_valid_q[NPORT];
    logic             out_valid_d[NPORT];
    logic [PKT_W-1:0] out_data_q [NPORT];
    logic [PKT_W-1:0] out_data_d [NPORT];

    logic             in_valid_c [NPORT];
    logic [PKT_W-1:0] in_data_c  [NPORT];
    logic             in_ready_c [NPORT];
    logic             out_ready_c[NPORT];
    logic [PKT_W-1:0] head_c     [NPORT];
    logic [1:0]       route_c    [NPORT];
    logic [2:0]       req_c      [NPORT];
    logic [2:0]       gnt_c      [NPORT];
    logic [2:0]       push_c;
    logic [2:0]       pop_c;

    // Round-robin pick: ptr names the highest-priority source this cycle.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
        logic [2:0] g;
        g = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1])      g = 3'b010;
                else if (req[2]) g = 3'b100;
                else if (req[0]) g = 3'b001;
            end
            2'd2: begin
                if (req[2])      g = 3'b100;
                else if (req[0]) g = 3'b001;
                else if (req[1]) g = 3'b010;
            end
            default: begin
                if (req[0])      g = 3'b001;
                else if (req[1]) g = 3'b010;
                else if (req[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    // Port bundling, ready generation, routing and arbitration.
    always_comb begin
        in_valid_c[0]  = i_valid_l;
        in_valid_c[1]  = i_valid_b;
        in_valid_c[2]  = i_valid_pe;
        in_data_c[0]   = i_data_l;
        in_data_c[1]   = i_data_b;
        in_data_c[2]   = i_data_pe;
        out_ready_c[0] = i_ready_r;
        out_ready_c[1] = i_ready_t;
        out_ready_c[2] = i_ready_ej;
        push_c         = 3'b000;
        pop_c          = 3'b000;

        for (int s = 0; s < NPORT; s++) begin
            in_ready_c[s] = !rst && (count_q[s] < CNT_W'(FIFO_DEPTH));
            push_c[s]     = in_valid_c[s] && in_ready_c[s];
            head_c[s]     = mem_q[s][rd_ptr_q[s]];
            if (head_c[s][PKT_W-1 -: X_W] != X_W'(X_COORD)) begin
                route_c[s] = OUT_R;
            end else if (head_c[s][PKT_W-X_W-1 -: Y_W] != Y_W'(Y_COORD)) begin
                route_c[s] = OUT_T;
            end else begin
                route_c[s] = OUT_EJ;
            end
        end

        for (int o = 0; o < NPORT; o++) begin
            req_c[o] = 3'b000;
            for (int s = 0; s < NPORT; s++) begin
                req_c[o][s] = (count_q[s] != '0) && (route_c[s] == 2'(o));
            end
            gnt_c[o] = (!out_valid_q[o] || out_ready_c[o]) ? rr_pick(rr_ptr_q[o], req_c[o]) : 3'b000;
        end

        for (int s = 0; s < NPORT; s++) begin
            pop_c[s] = gnt_c[0][s] || gnt_c[1][s] || gnt_c[2][s];
        end
    end

    // Next state for FIFOs, output registers and round-robin pointers.
    always_comb begin
        mem_d = mem_q;
        for (int s = 0; s < NPORT; s++) begin
            if (push_c[s]) begin
                mem_d[s][wr_ptr_q[s]] = in_data_c[s];
            end
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push_c[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(pop_c[s]);
            count_d[s]  = count_q[s] + CNT_W'(push_c[s]) - CNT_W'(pop_c[s]);
        end

        for (int o = 0; o < NPORT; o++) begin
            out_valid_d[o] = out_valid_q[o];
            out_data_d[o]  = out_data_q[o];
            rr_ptr_d[o]    = rr_ptr_q[o];
            if (gnt_c[o] != 3'b000) begin
                out_valid_d[o] = 1'b1;
                for (int s = 0; s < NPORT; s++) begin
                    if (gnt_c[o][s]) begin
                        out_data_d[o] = head_c[s];
                        rr_ptr_d[o]   = (s == NPORT - 1) ? 2'd0 : 2'(s + 1);
                    end
                end
            end else if (out_ready_c[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NPORT; s++) begin
                wr_ptr_q[s]    <= '0;
                rd_ptr_q[s]    <= '0;
                count_q[s]     <= '0;
                rr_ptr_q[s]    <= 2'd0;
                out_valid_q[s] <= 1'b0;
                out_data_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NPORT; s++) begin
                wr_ptr_q[s]    <= wr_ptr_d[s];
                rd_ptr_q[s]    <= rd_ptr_d[s];
                count_q[s]     <= count_d[s];
                rr_ptr_q[s]    <= rr_ptr_d[s];
                out_valid_q[s] <= out_valid_d[s];
                out_data_q[s]  <= out_data_d[s];
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_ready_l  = in_ready_c[0];
    assign o_ready_b  = in_ready_c[1];
    assign o_ready_pe = in_ready_c[2];
    assign o_valid_r  = out_valid_q[0];
    assign o_data_r   = out_data_q[0];
    assign o_valid_t  = out_valid_q[1];
    assign o_data_t   = out_data_q[1];
    assign o_valid_ej = out_valid_q[2];
    assign o_data_ej  = out_data_q[2];

endmodule
